// File: rtl/chebyshev_pkg.sv
// Shared definitions for the Chebyshev sequencer: FSM encoding, default widths
// and a constant-foldable clog2 helper.
package chebyshev_pkg;

  localparam int unsigned DefWordLength  = 16;
  localparam int unsigned DefCoeffLength = 16;
  localparam int unsigned DefDegree      = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } seq_state_e;

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/chebyshev_sequencer_if.sv
// Handshake and coefficient bus between the sequencer (slave) and its
// surroundings (master: upstream source, computation stage, consumer).
interface chebyshev_sequencer_if #(
  parameter int unsigned WordLength  = 16,
  parameter int unsigned CoeffLength = 16,
  parameter int unsigned AddrW       = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WordLength-1:0]  in_data;
  logic                   coef_we;
  logic [AddrW-1:0]       coef_addr;
  logic [CoeffLength-1:0] coef_wdata;
  logic                   cmp_valid;
  logic                   cmp_first;
  logic [WordLength-1:0]  cmp_data;
  logic [CoeffLength-1:0] cmp_coeff;
  logic [WordLength-1:0]  cmp_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [WordLength-1:0]  out_data;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, cmp_result, out_ready,
    output in_ready, cmp_valid, cmp_first, cmp_data, cmp_coeff, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, cmp_result, out_ready,
    input  in_ready, cmp_valid, cmp_first, cmp_data, cmp_coeff, out_valid, out_data, busy
  );
endinterface

// File: rtl/chebyshev_coeff_regfile.sv
// Coefficient table: one write port with enable, combinational read, async clear.
module chebyshev_coeff_regfile #(
  parameter int unsigned CoeffLength = 16,
  parameter int unsigned Entries     = 4,
  parameter int unsigned AddrW       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [AddrW-1:0]       waddr_i,
  input  logic [CoeffLength-1:0] wdata_i,
  input  logic [AddrW-1:0]       raddr_i,
  output logic [CoeffLength-1:0] rdata_o
);

  logic [CoeffLength-1:0] mem_q [Entries];

  // Per-entry address match, so addresses beyond the table simply hit nothing.
  for (genvar i = 0; i < Entries; i++) begin : g_entry
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mem_q[i] <= '0;
      end else if (we_i && (waddr_i == AddrW'(i))) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chebyshev_sequencer.sv
// Paces the Horner recurrence into the computation stage, highest degree first,
// and holds the returned result on a valid/ready output.
module chebyshev_sequencer
  import chebyshev_pkg::*;
#(
  parameter int unsigned WordLength  = DefWordLength,
  parameter int unsigned CoeffLength = DefCoeffLength,
  parameter int unsigned Degree      = DefDegree,
  parameter int unsigned PipeLatency = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  chebyshev_sequencer_if.slave bus
);

  localparam int unsigned AddrW = clog2(Degree + 1);
  localparam int unsigned WaitW = clog2(PipeLatency + 1);
  localparam logic [AddrW-1:0] KStart = AddrW'(Degree);
  // WAIT spans PipeLatency-1 cycles: load PipeLatency-2 and leave on zero.
  localparam logic [WaitW-1:0] WaitLoad = (PipeLatency > 1) ? WaitW'(PipeLatency - 2) : '0;

  seq_state_e             state_q, state_d;
  logic [AddrW-1:0]       k_q, k_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic [WordLength-1:0]  x_q, x_d;
  logic [WordLength-1:0]  out_q, out_d;
  logic [CoeffLength-1:0] coef_rdata;
  logic                   accept;
  logic                   term_done;

  chebyshev_coeff_regfile #(
    .CoeffLength(CoeffLength),
    .Entries    (Degree + 1),
    .AddrW      (AddrW)
  ) u_regfile (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (bus.coef_we && !bus.busy),
    .waddr_i(bus.coef_addr),
    .wdata_i(bus.coef_wdata),
    .raddr_i(k_q),
    .rdata_o(coef_rdata)
  );

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      wait_q  <= '0;
      x_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      x_q     <= x_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wait_d    = wait_q;
    x_d       = x_q;
    out_d     = out_q;
    term_done = 1'b0;
    unique case (state_q)
      StIdle: if (accept) state_d = StIssue;
      StIssue: begin
        if (PipeLatency > 1) begin
          state_d = StWait;
          wait_d  = WaitLoad;
        end else begin
          term_done = 1'b1;
        end
      end
      StWait: begin
        if (wait_q == '0) term_done = 1'b1;
        else              wait_d = wait_q - 1'b1;
      end
      StHold: if (bus.out_ready) state_d = accept ? StIssue : StIdle;
    endcase
    if (term_done) begin
      if (k_q == '0) begin
        state_d = StHold;
        out_d   = bus.cmp_result;
      end else begin
        state_d = StIssue;
        k_d     = k_q - 1'b1;
      end
    end
    if (accept) begin
      x_d = bus.in_data;
      k_d = KStart;
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.cmp_valid = 1'b0;
    bus.cmp_first = 1'b0;
    bus.cmp_coeff = '0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      StIdle: bus.in_ready = !rst_i;
      StIssue: begin
        bus.cmp_valid = 1'b1;
        bus.cmp_first = (k_q == KStart);
        bus.cmp_coeff = coef_rdata;
        bus.busy      = 1'b1;
      end
      StWait: bus.busy = 1'b1;
      StHold: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
    endcase
  end

  assign bus.cmp_data = x_q;
  assign bus.out_data = out_q;

endmodule
